// File: rtl/popcount_seq.sv
// Sequential ones/zeros counter: walks a latched word CHUNK_W bits per clock and
// keeps a saturating running total of the per-word counts.
module popcount_seq #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8,
    parameter int RET_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_mode,
    input  logic                        i_acc,
    input  logic                        i_clr,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [$clog2(DATA_W+1)-1:0] o_cnt,
    output logic [RET_W-1:0]            o_acc,
    output logic                        o_sat
);
    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SUM_W  = ((RET_W > CNT_W) ? RET_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = (SUM_W'(1) << RET_W) - SUM_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    generate
        if (CHUNK_W < 1 || (DATA_W % CHUNK_W) != 0) begin : g_param_chk
            $error("popcount_seq: DATA_W must be a non-zero multiple of CHUNK_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  word_q;
    logic               acc_flag_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   part_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RET_W-1:0]   acc_q;
    logic               sat_q;
    logic               ready_q;
    logic               valid_q;

    logic [CNT_W-1:0]   part_d;
    logic [SUM_W-1:0]   sum_d;
    logic [RET_W-1:0]   acc_d;
    logic               ovf_d;

    function automatic logic [CNT_W-1:0] popcnt(input logic [CHUNK_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_W; i++) n += CNT_W'(v[i]);
        return n;
    endfunction

    // The word shifts right each CALC cycle, so the active chunk is always the low slice.
    always_comb begin
        part_d = part_q + popcnt(word_q[CHUNK_W-1:0]);
        sum_d  = acc_flag_q ? (SUM_W'(acc_q) + SUM_W'(part_d)) : SUM_W'(part_d);
        ovf_d  = 1'b0;
        acc_d  = sum_d[RET_W-1:0];
        if (sum_d > ACC_MAX) begin
            ovf_d = 1'b1;
            acc_d = ACC_MAX[RET_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            acc_flag_q <= 1'b0;
            idx_q      <= '0;
            part_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        word_q     <= i_mode ? ~i_data : i_data;
                        acc_flag_q <= i_acc;
                        idx_q      <= '0;
                        part_q     <= '0;
                        ready_q    <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    word_q <= word_q >> CHUNK_W;
                    part_q <= part_d;
                    idx_q  <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        cnt_q   <= part_d;
                        valid_q <= 1'b1;
                        acc_q   <= acc_d;
                        sat_q   <= sat_q | ovf_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Clear wins over a same-cycle accumulator update.
            if (i_clr) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_cnt   = cnt_q;
    assign o_acc   = acc_q;
    assign o_sat   = sat_q;
endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq (8-bit word, 4-bit chunks, 4-bit accumulator): timeline model
// compared every cycle, plus directed literal checks and randomized words.
module tb_popcount_seq;
    localparam int DW     = 8;
    localparam int CW     = 4;
    localparam int RW     = 4;
    localparam int NCH    = DW / CW;
    localparam int CNTW   = $clog2(DW + 1);
    localparam int MAXACC = (1 << RW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_valid = 1'b0;
    logic            i_mode = 1'b0;
    logic            i_acc = 1'b0;
    logic            i_clr = 1'b0;
    logic            i_ready = 1'b0;
    logic [DW-1:0]   i_data = '0;
    logic            o_ready, o_valid, o_sat;
    logic [CNTW-1:0] o_cnt;
    logic [RW-1:0]   o_acc;

    int n_tests = 0;
    int n_fail  = 0;

    popcount_seq #(.DATA_W(DW), .CHUNK_W(CW), .RET_W(RW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .i_mode(i_mode), .i_acc(i_acc), .i_clr(i_clr), .o_valid(o_valid),
        .i_ready(i_ready), .o_cnt(o_cnt), .o_acc(o_acc), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a word sits NCH cycles in flight after acceptance, then is presented until taken.
    bit m_ready, m_valid, m_pacc, m_sat;
    int m_timer, m_cnt, m_pend, m_acc, m_sum;

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1; m_valid = 0; m_cnt = 0; m_acc = 0; m_sat = 0; m_timer = 0;
        end else begin
            if (m_ready && i_valid) begin
                m_pend  = $countones(i_mode ? ~i_data : i_data);
                m_pacc  = i_acc;
                m_timer = NCH;
                m_ready = 0;
            end else if (m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_valid = 1;
                    m_cnt   = m_pend;
                    m_sum   = m_pacc ? m_acc + m_pend : m_pend;
                    if (m_sum > MAXACC) begin m_acc = MAXACC; m_sat = 1; end
                    else m_acc = m_sum;
                end
            end else if (m_valid && i_ready) begin
                m_valid = 0;
                m_ready = 1;
            end
            if (i_clr) begin m_acc = 0; m_sat = 0; end
        end
        #1;
        chk("cyc_ready", o_ready, m_ready);
        chk("cyc_valid", o_valid, m_valid);
        chk("cyc_acc", o_acc, m_acc);
        chk("cyc_sat", o_sat, m_sat);
        if (m_valid) chk("cyc_cnt", o_cnt, m_cnt);
    end

    task automatic run_word(input logic [DW-1:0] d, input bit m, input bit a, input int hold,
                            input int clr_at, input bit rnd, output int lat,
                            output logic [CNTW-1:0] cnt);
        int guard = 0;
        @(negedge clk);
        while (!o_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!o_ready) chk("ready_timeout", o_ready, 1);
        i_valid = 1; i_data = d; i_mode = m; i_acc = a; i_ready = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            i_valid = 0;
            i_data  = DW'($urandom);
            i_mode  = 1'($urandom);
            i_acc   = 1'($urandom);
            i_clr   = (lat == clr_at) || (rnd && $urandom_range(0, 7) == 0);
        end while (!o_valid && lat < 50);
        if (!o_valid) chk("valid_timeout", o_valid, 1);
        cnt = o_cnt;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", o_valid, 1);
            chk("hold_cnt", o_cnt, cnt);
            chk("hold_ready", o_ready, 0);
            i_valid = 1'($urandom);
            i_data  = DW'($urandom);
            i_clr   = rnd && ($urandom_range(0, 7) == 0);
        end
        i_valid = 0; i_ready = 1;
        @(negedge clk);
        i_ready = 0; i_clr = 0;
        chk("release_ready", o_ready, 1);
        chk("release_valid", o_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [CNTW-1:0] cnt;
        logic [DW-1:0] d;
        bit m, a;

        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_cnt", o_cnt, 0);
        chk("rst_acc", o_acc, 0);
        chk("rst_sat", o_sat, 0);

        run_word(8'b0111_0001, 0, 0, 0, -1, 0, lat, cnt);
        chk("t1_latency", lat, 3);
        chk("t1_cnt", cnt, 4);

        run_word(8'b0111_0001, 1, 0, 0, -1, 0, lat, cnt); chk("t2_zeros_71", cnt, 4);
        run_word(8'h00, 1, 0, 0, -1, 0, lat, cnt);        chk("t2_zeros_00", cnt, 8);
        run_word(8'hFF, 0, 0, 0, -1, 0, lat, cnt);        chk("t2_ones_ff", cnt, 8);
        run_word(8'h00, 0, 0, 0, -1, 0, lat, cnt);        chk("t2_ones_00", cnt, 0);

        run_word(8'h3C, 0, 0, 5, -1, 0, lat, cnt);        chk("t3_backpressure_cnt", cnt, 4);

        @(negedge clk); i_clr = 1;
        @(negedge clk); i_clr = 0;
        chk("t4_clr_acc", o_acc, 0);
        run_word(8'hFF, 0, 1, 0, -1, 0, lat, cnt);
        chk("t4_acc_8", o_acc, 8);
        chk("t4_sat_0", o_sat, 0);
        run_word(8'hFF, 0, 1, 0, -1, 0, lat, cnt);
        chk("t4_acc_15", o_acc, 15);
        chk("t4_sat_1", o_sat, 1);
        run_word(8'hFF, 0, 0, 0, -1, 0, lat, cnt);
        chk("t4_load_8", o_acc, 8);
        chk("t4_sat_sticky", o_sat, 1);

        run_word(8'b0111_0001, 0, 1, 0, 2, 0, lat, cnt);
        chk("t5_cnt", cnt, 4);
        chk("t5_acc", o_acc, 0);
        chk("t5_sat", o_sat, 0);

        @(negedge clk); i_valid = 1; i_data = 8'hFF; i_mode = 0; i_acc = 1;
        @(negedge clk); i_valid = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        chk("t6_ready", o_ready, 1);
        chk("t6_acc", o_acc, 0);
        repeat (6) begin @(negedge clk); chk("t6_no_valid", o_valid, 0); end
        run_word(8'hA5, 0, 0, 0, -1, 0, lat, cnt);
        chk("t6_next_cnt", cnt, 4);

        for (int k = 0; k < 150; k++) begin
            d = DW'($urandom);
            m = 1'($urandom);
            a = 1'($urandom);
            run_word(d, m, a, $urandom_range(0, 3), -1, 1, lat, cnt);
            chk("rnd_latency", lat, NCH + 1);
            chk("rnd_cnt", cnt, $countones(m ? ~d : d));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
